// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment animation sequencer: state codes,
// per-animation frame counts and prescaler width.
package seg7_pkg;

    localparam int unsigned PRESCALE_W = 24;
    localparam int unsigned ANIM_W     = 3;
    localparam int unsigned FRAME_W    = 4;
    localparam int unsigned LOOP_W     = 4;

    typedef enum logic [ANIM_W-1:0] {
        ST_IDLE = 3'd0,
        ST_ANI1 = 3'd1,
        ST_ANI2 = 3'd2,
        ST_ANI3 = 3'd3,
        ST_ANI4 = 3'd4,
        ST_ANI5 = 3'd5
    } seg7_state_t;

    // Entry [0] is the digit counter, [1]..[5] are ANI1..ANI5.
    localparam logic [5:0][FRAME_W-1:0] FRAME_COUNT = {
        4'd6, 4'd6, 4'd7, 4'd7, 4'd7, 4'd10
    };

    function automatic logic [FRAME_W-1:0] frame_last(input seg7_state_t s);
        logic [FRAME_W-1:0] last;
        case (s)
            ST_IDLE: last = FRAME_COUNT[0] - FRAME_W'(1);
            ST_ANI1: last = FRAME_COUNT[1] - FRAME_W'(1);
            ST_ANI2: last = FRAME_COUNT[2] - FRAME_W'(1);
            ST_ANI3: last = FRAME_COUNT[3] - FRAME_W'(1);
            ST_ANI4: last = FRAME_COUNT[4] - FRAME_W'(1);
            ST_ANI5: last = FRAME_COUNT[5] - FRAME_W'(1);
            default: last = '0;
        endcase
        return last;
    endfunction

    function automatic seg7_state_t next_anim(input seg7_state_t s);
        seg7_state_t n;
        case (s)
            ST_IDLE: n = ST_ANI1;
            ST_ANI1: n = ST_ANI2;
            ST_ANI2: n = ST_ANI3;
            ST_ANI3: n = ST_ANI4;
            ST_ANI4: n = ST_ANI5;
            default: n = ST_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Free-running frame-rate prescaler; raises adv_tick_c in the cycle the count
// reaches the selected compare value.
module seg7_prescaler
    import seg7_pkg::*;
#(
    parameter logic [PRESCALE_W-1:0] MAX_COUNT = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] speed,
    output logic       adv_tick_c,
    output logic [7:0] dbg_count
);

    logic [PRESCALE_W-1:0] count_q;
    logic [PRESCALE_W-1:0] compare_c;

    assign compare_c  = (speed == 8'd0) ? MAX_COUNT : {6'b0, speed, 10'b0};
    // >= so a live drop of compare below count ticks at once instead of wrapping
    assign adv_tick_c = (count_q >= compare_c);
    assign dbg_count  = count_q[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (adv_tick_c) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/seg7_anim_sequencer.sv
// Animation playlist sequencer: walks digit counter then ANI1..ANI5, with
// per-animation loop count, hold/single-step and sequence-wrap reporting.
module seg7_anim_sequencer
    import seg7_pkg::*;
#(
    parameter logic [PRESCALE_W-1:0] MAX_COUNT = 24'd10_000_000,
    parameter int unsigned           LOOPS     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] speed,
    input  logic       hold,
    input  logic       step,
    output logic [2:0] anim_sel,
    output logic [3:0] frame,
    output logic       frame_tick,
    output logic       seq_wrap,
    output logic [7:0] dbg_count
);

    localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(LOOPS - 1);

    seg7_state_t          state_q, state_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [LOOP_W-1:0]    loop_q, loop_d;
    logic                 frame_tick_q, frame_tick_d;
    logic                 seq_wrap_q, seq_wrap_d;
    logic                 adv_tick_c;
    logic                 advance_c;

    seg7_prescaler #(
        .MAX_COUNT (MAX_COUNT)
    ) u_prescaler (
        .clk        (clk),
        .reset      (reset),
        .speed      (speed),
        .adv_tick_c (adv_tick_c),
        .dbg_count  (dbg_count)
    );

    // Hold hands frame advance to step; the prescaler keeps running regardless.
    assign advance_c = hold ? step : adv_tick_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            frame_q      <= '0;
            loop_q       <= '0;
            frame_tick_q <= 1'b0;
            seq_wrap_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            loop_q       <= loop_d;
            frame_tick_q <= frame_tick_d;
            seq_wrap_q   <= seq_wrap_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        loop_d       = loop_q;
        frame_tick_d = 1'b0;
        seq_wrap_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_ANI1, ST_ANI2, ST_ANI3, ST_ANI4, ST_ANI5: begin
                if (advance_c) begin
                    frame_tick_d = 1'b1;
                    if (frame_q < frame_last(state_q)) begin
                        frame_d = frame_q + FRAME_W'(1);
                    end else begin
                        frame_d = '0;
                        if (loop_q < LOOP_LAST) begin
                            loop_d = loop_q + LOOP_W'(1);
                        end else begin
                            loop_d     = '0;
                            state_d    = next_anim(state_q);
                            seq_wrap_d = (state_q == ST_ANI5);
                        end
                    end
                end
            end
            // Unreachable codes recover silently to the start of the playlist.
            default: begin
                state_d = ST_IDLE;
                frame_d = '0;
                loop_d  = '0;
            end
        endcase
    end

    assign anim_sel   = state_q;
    assign frame      = frame_q;
    assign frame_tick = frame_tick_q;
    assign seq_wrap   = seq_wrap_q;

endmodule

// File: doc/seg7_anim_sequencer.md
# seg7_anim_sequencer

Controller that sequences the seven-segment pattern datapath. It generates the frame-rate tick from a programmable prescaler and walks the six-entry animation playlist: the digit counter, then animations 1–5. For each step it drives the pattern-decoder select and the frame index. It replaces ad-hoc per-animation counting with one FSM that supports loop counts, hold and single-step, and reports sequence wrap.

## Interface
Parameters:
- `MAX_COUNT`, 24'd10_000_000: prescaler compare value used when `speed` == 0.
- `LOOPS`, 2: full passes of each animation before advancing to the next one; legal range 1–15.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `speed`  in  8  prescaler select; 0 selects `MAX_COUNT`, otherwise compare = {6'b0, speed, 10'b0}.
- `hold`  in  1  freeze frame advance.
- `step`  in  1  single-cycle pulse; advances one frame while `hold`=1.
- `anim_sel`  out  3  active decoder: 0 = digit counter, 1–5 = ANI1–ANI5.
- `frame`  out  4  frame index presented to the selected decoder.
- `frame_tick`  out  1  one-cycle pulse, coincident with each new `frame`/`anim_sel` value.
- `seq_wrap`  out  1  one-cycle pulse when the sequence returns from ANI5 to the digit counter.
- `dbg_count`  out  8  prescaler count bits [7:0].

## Operation
- Frames per animation: digit counter 10 (indices 0–9), ANI1–ANI3 7 (0–6), ANI4–ANI5 6 (0–5).
- Prescaler:
  - 24-bit count, incremented every cycle.
  - When count >= compare: `adv_tick` is raised internally and count returns to 0.
  - Using `>=` means a live drop of compare below the current count produces a tick on the next cycle, not a 2^24 wrap.
  - The prescaler always runs, including during `hold`.
- Advance event:
  - `hold`=0: `adv_tick`.
  - `hold`=1: `step`.
  - `adv_tick` is discarded while `hold`=1. `step` is ignored while `hold`=0.
- On an advance:
  - If `frame` < last index of the current animation: `frame`+1.
  - Otherwise `frame` returns to 0 and the loop counter is checked:
    - loop counter < `LOOPS`-1: loop counter +1, `anim_sel` unchanged.
    - loop counter = `LOOPS`-1: loop counter returns to 0 and `anim_sel` moves to the next animation in 0→1→2→3→4→5→0. The 5→0 transition also pulses `seq_wrap`.
- FSM states are IDLE_DIGITS and ANI1–ANI5, encoded 0–5. `anim_sel` equals the state.
- Codes 6 and 7 are unreachable. If they occur, the next cycle forces state 0 with `frame`=0 and loop counter 0, and no pulses are generated.
- Reset, asynchronous: count, `anim_sel`, `frame`, loop counter, `frame_tick`, `seq_wrap` and `dbg_count` all return to 0. Outputs go to 0 immediately on assertion, mid-frame included.

## Timing
- `adv_tick` is asserted in cycle N, the cycle where count >= compare. `frame`, `anim_sel`, `frame_tick` and `seq_wrap` are registered and update at the edge ending cycle N, visible in cycle N+1.
- Tick period is compare+1 cycles.
- `step` latency is 1 cycle, same as a tick. Back-to-back `step` pulses advance one frame per cycle.
- `step` coincident with `adv_tick` under `hold`=1 gives exactly one advance.
- A change on `speed` takes effect on the next comparison; it is not synchronized.
- After reset deasserts, the first tick arrives compare+1 cycles later.

## Structure
- Shared package `seg7_pkg` holds:
  - the state/`anim_sel` localparams (ST_IDLE…ST_ANI5);
  - the frame-count table: 10, 7, 7, 7, 6, 6;
  - the 24-bit prescaler width constant.
- One sub-module, `seg7_prescaler`, holds the compare mux, the counter, `adv_tick` generation and `dbg_count`.
- The sequencer FSM, loop counter and frame counter stay in `seg7_anim_sequencer`.

## Test plan
- Reset mid-run:
  - Stimulus: `MAX_COUNT`=4, run to `anim_sel`=2, `frame`=3, then assert `reset` between clock edges.
  - Required: all outputs 0 without waiting for a clock edge; the first `frame_tick` comes 5 cycles after deassertion.
- Basic rate and loop advance:
  - Stimulus: `MAX_COUNT`=4, `speed`=0, `LOOPS`=2.
  - Required: `frame_tick` every 5 cycles and `frame` 0…9,0…9. The 20th tick shows `anim_sel`=1 with `frame`=0.
- Full sequence:
  - Stimulus: `MAX_COUNT`=4, `LOOPS`=2.
  - Required: `seq_wrap` on the 86th tick, i.e. 2×(10+7+7+7+6+6) ticks, with `anim_sel` back to 0, `frame`=0, and `seq_wrap` high for exactly 1 cycle.
- Hold and step:
  - Stimulus 1: with `hold`=1, run 50 cycles. Required: `frame` constant, no `frame_tick`.
  - Stimulus 2: 3 `step` pulses. Required: `frame` +3 with 3 `frame_tick` pulses.
  - Stimulus 3: `step` with `hold`=0 and no tick due. Required: no change.
- Programmed speed:
  - Stimulus: `speed`=1.
  - Required: tick period 1025 cycles. With `speed`=2, period 2049.
- Compare drop:
  - Stimulus: `speed`=4 (compare 4096); at count 3000, switch to `speed`=1.
  - Required: tick on the next cycle, then period 1025.
